// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the LED fade sequencer: FSM state codes,
// default duty width and hold counter width.
package pwm_fade_ctrl_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int HOLD_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HI   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LO   = 3'd4
  } fade_st_t;

endpackage

// File: rtl/pwm_fade_ctrl_tick_gen.sv
// Prescaler for the fade sequencer: emits a 1-clk tick every TICK_DIV
// clks while run=1. Ports: clk, rst (async, high), clr, run, tick.
module pwm_tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = run && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      if (tick) cnt_q <= '0;
      else      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing-LED sequencer driving pwm.duty: ramp up, hold, ramp down,
// hold, repeat. Ports: clk, rst, en, step, duty_min, duty_max,
// hold_ticks in; duty, phase (state code), cycle_done out.
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int DUTY_W   = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] step,
  input  logic [DUTY_W-1:0] duty_min,
  input  logic [DUTY_W-1:0] duty_max,
  input  logic [HOLD_W-1:0] hold_ticks,
  output logic [DUTY_W-1:0] duty,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  fade_st_t state_q, state_d;

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic [DUTY_W-1:0] min_q, min_d;
  logic [DUTY_W-1:0] max_q, max_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              done_q, done_d;

  logic              tick;
  logic              tclr;
  logic              trun;
  logic              degen;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_dif;

  // The prescaler is held at zero in IDLE and on any en=0 edge, so a
  // run always starts with a full TICK_DIV interval.
  assign trun = (state_q != ST_IDLE);
  assign tclr = (state_q == ST_IDLE) || !en;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tclr),
    .run  (trun),
    .tick (tick)
  );

  // A run captured with min>=max parks in HOLD_LO with no exit.
  assign degen = (min_q >= max_q);

  // One extra bit so the sum/difference can saturate instead of wrap.
  assign up_sum = {1'b0, duty_q} + {1'b0, step_q};
  assign dn_dif = {1'b0, duty_q} - {1'b0, step_q};

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    step_d  = step_q;
    min_d   = min_q;
    max_d   = max_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          step_d = (step == '0) ? DUTY_W'(1) : step;
          min_d  = duty_min;
          max_d  = duty_max;
          hold_d = hold_ticks;
          duty_d = duty_min;
          hcnt_d = '0;
          if (duty_min >= duty_max)
            state_d = ST_HOLD_LO;
          else
            state_d = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (tick) begin
            if (up_sum >= {1'b0, max_q}) begin
              duty_d  = max_q;
              hcnt_d  = hold_q;
              state_d = ST_HOLD_HI;
            end else begin
              duty_d = up_sum[DUTY_W-1:0];
            end
          end
        end
        ST_HOLD_HI: begin
          if (tick) begin
            if (hcnt_q == '0)
              state_d = ST_RAMP_DOWN;
            else
              hcnt_d = hcnt_q - HOLD_W'(1);
          end
        end
        ST_RAMP_DOWN: begin
          if (tick) begin
            if (dn_dif[DUTY_W] ||
                (dn_dif[DUTY_W-1:0] <= min_q)) begin
              duty_d  = min_q;
              hcnt_d  = hold_q;
              state_d = ST_HOLD_LO;
            end else begin
              duty_d = dn_dif[DUTY_W-1:0];
            end
          end
        end
        ST_HOLD_LO: begin
          if (tick && !degen) begin
            if (hcnt_q == '0) begin
              state_d = ST_RAMP_UP;
              done_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q - HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      step_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      step_q  <= step_d;
      min_q   <= min_d;
      max_q   <= max_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
    end
  end

  assign duty       = duty_q;
  assign phase      = state_q;
  assign cycle_done = done_q;

endmodule
